hvsync_ram_fb: RTL and testbench

- Video scan block: a 256x240 raster timing generator plus a 4096x8 framebuffer RAM.
- The RAM is read asynchronously at the scan position and written synchronously from a host port.
- Outputs are active-high H/V sync, scan position, a display-enable flag and a 3-bit BGR pixel taken from the addressed RAM byte.
- It sits between the frame-drawing logic (host write port) and the video output pins.

---
 rtl/hvsync_ram_fb_if.sv | 29 ++
 rtl/hvsync_ram_fb.sv | 79 +++++++
 tb/tb_hvsync_ram_fb.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hvsync_ram_fb_if.sv
// Host write port and video output bundle for the
// raster scan framebuffer.
interface hvsync_ram_fb_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  hsync;
  logic                  vsync;
  logic                  display_on;
  logic [8:0]            hpos;
  logic [8:0]            vpos;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [2:0]            rgb;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  hsync, vsync, display_on,
    input  hpos, vpos, rd_data, rgb
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output hsync, vsync, display_on,
    output hpos, vpos, rd_data, rgb
  );
endinterface

// File: rtl/hvsync_ram_fb.sv
// 256x240 raster timing generator with a 4096x8
// framebuffer read asynchronously at the scan position.
module hvsync_ram_fb #(
  parameter int H_DISPLAY  = 256,
  parameter int H_BACK     = 23,
  parameter int H_FRONT    = 7,
  parameter int H_SYNC     = 23,
  parameter int V_DISPLAY  = 240,
  parameter int V_TOP      = 5,
  parameter int V_BOTTOM   = 14,
  parameter int V_SYNC     = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  hvsync_ram_fb_if.slave bus
);
  localparam logic [8:0] H_MAX =
    9'(H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1);
  localparam logic [8:0] H_SS =
    9'(H_DISPLAY + H_FRONT);
  localparam logic [8:0] H_SE =
    9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [8:0] V_MAX =
    9'(V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1);
  localparam logic [8:0] V_SS =
    9'(V_DISPLAY + V_BOTTOM);
  localparam logic [8:0] V_SE =
    9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam logic [8:0] H_VIS = 9'(H_DISPLAY);
  localparam logic [8:0] V_VIS = 9'(V_DISPLAY);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [8:0]            hpos_q, hpos_d;
  logic [8:0]            vpos_q, vpos_d;
  logic                  h_end;
  logic                  disp;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    h_end  = (hpos_q == H_MAX);
    hpos_d = h_end ? 9'd0 : hpos_q + 9'd1;
    vpos_d = vpos_q;
    if (h_end) begin
      vpos_d = (vpos_q == V_MAX) ? 9'd0 : vpos_q + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hpos_q <= 9'd0;
      vpos_q <= 9'd0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  // RAM is deliberately outside reset so frame data survives it
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign scan_addr =
    ADDR_WIDTH'({vpos_q[6:0], hpos_q[4:0]});
  assign disp = (hpos_q < H_VIS) && (vpos_q < V_VIS);

  assign bus.hpos       = hpos_q;
  assign bus.vpos       = vpos_q;
  assign bus.hsync      = (hpos_q >= H_SS) && (hpos_q <= H_SE);
  assign bus.vsync      = (vpos_q >= V_SS) && (vpos_q <= V_SE);
  assign bus.display_on = disp;
  assign bus.rd_data    = mem_q[scan_addr];
  assign bus.rgb        = bus.rd_data[2:0] & {3{disp}};
endmodule

// File: tb/tb_hvsync_ram_fb.sv
// Randomised bench for hvsync_ram_fb against a
// position-count reference model.
module tb_hvsync_ram_fb;
  localparam int HT = 309;
  localparam int FT = 80958;
  localparam int PIX_A = 101;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   p;
  logic [7:0] mem_m [4096];

  hvsync_ram_fb_if bus ();

  hvsync_ram_fb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int eh(int q);
    return q % HT;
  endfunction

  function automatic int ev(int q);
    return q / HT;
  endfunction

  function automatic logic ehs(int q);
    return eh(q) >= 263 && eh(q) <= 285;
  endfunction

  function automatic logic evs(int q);
    return ev(q) >= 254 && ev(q) <= 256;
  endfunction

  function automatic logic edisp(int q);
    return eh(q) < 256 && ev(q) < 240;
  endfunction

  function automatic int eaddr(int q);
    return (ev(q) % 128) * 32 + (eh(q) % 32);
  endfunction

  function automatic logic [2:0] ergb(int q);
    logic [7:0] d;
    d = mem_m[eaddr(q)];
    return edisp(q) ? d[2:0] : 3'b000;
  endfunction

  task automatic step();
    logic       we;
    logic [11:0] a;
    logic [7:0] d;
    logic       r;
    we = bus.wr_en;
    a  = bus.wr_addr;
    d  = bus.wr_data;
    r  = reset;
    @(posedge clk);
    if (we) mem_m[a] = d;
    p = r ? (p + 1) % FT : 0;
    #1;
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    repeat (n) step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(3);
    checks += 5;
    if (bus.hpos !== 9'd0) begin
      failures++;
      $display("FAIL rst_hpos got=%0d exp=0", bus.hpos);
    end
    if (bus.vpos !== 9'd0) begin
      failures++;
      $display("FAIL rst_vpos got=%0d exp=0", bus.vpos);
    end
    if (bus.hsync !== 1'b0) begin
      failures++;
      $display("FAIL rst_hsync got=%b exp=0", bus.hsync);
    end
    if (bus.vsync !== 1'b0) begin
      failures++;
      $display("FAIL rst_vsync got=%b exp=0", bus.vsync);
    end
    if (bus.display_on !== 1'b1) begin
      failures++;
      $display("FAIL rst_disp got=%b exp=1", bus.display_on);
    end
    repeat (255) step();
    checks += 2;
    if (bus.hpos !== 9'd255) begin
      failures++;
      $display("FAIL h255 got=%0d exp=255", bus.hpos);
    end
    if (bus.display_on !== 1'b1) begin
      failures++;
      $display("FAIL disp255 got=%b exp=1", bus.display_on);
    end
    step();
    checks += 2;
    if (bus.hpos !== 9'd256) begin
      failures++;
      $display("FAIL h256 got=%0d exp=256", bus.hpos);
    end
    if (bus.display_on !== 1'b0) begin
      failures++;
      $display("FAIL disp256 got=%b exp=0", bus.display_on);
    end
  endtask

  task automatic test_horizontal();
    int first_hs;
    int hs_len;
    do_reset(1);
    first_hs = -1;
    hs_len   = 0;
    for (int i = 0; i < HT + 3; i++) begin
      checks += 3;
      if (bus.hpos !== 9'(eh(p))) begin
        failures++;
        $display("FAIL line_hpos got=%0d exp=%0d",
                 bus.hpos, eh(p));
      end
      if (bus.vpos !== 9'(ev(p))) begin
        failures++;
        $display("FAIL line_vpos got=%0d exp=%0d",
                 bus.vpos, ev(p));
      end
      if (bus.hsync !== ehs(p)) begin
        failures++;
        $display("FAIL line_hsync h=%0d got=%b exp=%b",
                 eh(p), bus.hsync, ehs(p));
      end
      if (bus.hsync === 1'b1) begin
        if (first_hs < 0) first_hs = int'(bus.hpos);
        hs_len++;
      end
      step();
    end
    checks += 2;
    if (first_hs != 263) begin
      failures++;
      $display("FAIL hs_start got=%0d exp=263", first_hs);
    end
    if (hs_len != 23) begin
      failures++;
      $display("FAIL hs_width got=%0d exp=23", hs_len);
    end
  endtask

  task automatic test_blanking();
    do_reset(1);
    for (int a = 0; a < 4096; a++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 12'(a);
      bus.wr_data = 8'hFF;
      step();
      if (p >= 2 * HT) begin
        checks++;
        if (bus.rgb !== (edisp(p) ? 3'b111 : 3'b000)) begin
          failures++;
          $display("FAIL blank_rgb h=%0d v=%0d got=%b",
                   eh(p), ev(p), bus.rgb);
        end
      end
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_pixel();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 12'(PIX_A);
    bus.wr_data = 8'h05;
    step();
    bus.wr_en = 1'b0;
    do_reset(1);
    while (p != 3 * HT + 5) step();
    checks += 2;
    if (bus.rd_data !== 8'h05) begin
      failures++;
      $display("FAIL pix_rd got=%h exp=05", bus.rd_data);
    end
    if (bus.rgb !== 3'b101) begin
      failures++;
      $display("FAIL pix_rgb got=%b exp=101", bus.rgb);
    end
    repeat (32) step();
    checks++;
    if (bus.rgb !== 3'b101) begin
      failures++;
      $display("FAIL pix_halias got=%b exp=101", bus.rgb);
    end
  endtask

  task automatic test_frame();
    int a;
    do_reset(1);
    for (int i = 0; i < FT; i++) begin
      checks += 7;
      if (bus.hpos !== 9'(eh(p))) begin
        failures++;
        $display("FAIL fr_hpos got=%0d exp=%0d",
                 bus.hpos, eh(p));
      end
      if (bus.vpos !== 9'(ev(p))) begin
        failures++;
        $display("FAIL fr_vpos got=%0d exp=%0d",
                 bus.vpos, ev(p));
      end
      if (bus.hsync !== ehs(p)) begin
        failures++;
        $display("FAIL fr_hsync p=%0d got=%b", p, bus.hsync);
      end
      if (bus.vsync !== evs(p)) begin
        failures++;
        $display("FAIL fr_vsync v=%0d got=%b exp=%b",
                 ev(p), bus.vsync, evs(p));
      end
      if (bus.display_on !== edisp(p)) begin
        failures++;
        $display("FAIL fr_disp p=%0d got=%b", p, bus.display_on);
      end
      if (bus.rd_data !== mem_m[eaddr(p)]) begin
        failures++;
        $display("FAIL fr_rd p=%0d got=%h exp=%h",
                 p, bus.rd_data, mem_m[eaddr(p)]);
      end
      if (bus.rgb !== ergb(p)) begin
        failures++;
        $display("FAIL fr_rgb p=%0d got=%b exp=%b",
                 p, bus.rgb, ergb(p));
      end
      if (p == 131 * HT + 5) begin
        checks++;
        if (bus.rgb !== 3'b101) begin
          failures++;
          $display("FAIL fr_valias got=%b exp=101", bus.rgb);
        end
      end
      bus.wr_en = 1'b0;
      if ($urandom_range(63) == 0) begin
        a = int'($urandom_range(4095));
        if (a == PIX_A) a = a + 1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 12'(a);
        bus.wr_data = 8'($urandom);
      end
      step();
    end
    bus.wr_en = 1'b0;
    checks += 2;
    if (bus.hpos !== 9'd0) begin
      failures++;
      $display("FAIL fr_wrap_h got=%0d exp=0", bus.hpos);
    end
    if (bus.vpos !== 9'd0) begin
      failures++;
      $display("FAIL fr_wrap_v got=%0d exp=0", bus.vpos);
    end
  endtask

  task automatic test_write_during_read();
    reset = 1'b0;
    step();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 12'd0;
    bus.wr_data = 8'h01;
    step();
    bus.wr_data = 8'h02;
    #1;
    checks += 2;
    if (bus.rd_data !== 8'h01) begin
      failures++;
      $display("FAIL wdr_old_rd got=%h exp=01", bus.rd_data);
    end
    if (bus.rgb !== 3'b001) begin
      failures++;
      $display("FAIL wdr_before got=%b exp=001", bus.rgb);
    end
    step();
    bus.wr_en = 1'b0;
    checks += 2;
    if (bus.rgb !== 3'b010) begin
      failures++;
      $display("FAIL wdr_after got=%b exp=010", bus.rgb);
    end
    if (bus.hpos !== 9'd0) begin
      failures++;
      $display("FAIL wdr_hold got=%0d exp=0", bus.hpos);
    end
    reset = 1'b1;
  endtask

  task automatic test_reset_midframe();
    int n;
    n = int'($urandom_range(2000, 500));
    repeat (n) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks += 3;
    if (bus.hpos !== 9'd0) begin
      failures++;
      $display("FAIL mid_hpos got=%0d exp=0", bus.hpos);
    end
    if (bus.vpos !== 9'd0) begin
      failures++;
      $display("FAIL mid_vpos got=%0d exp=0", bus.vpos);
    end
    if (bus.rd_data !== mem_m[0]) begin
      failures++;
      $display("FAIL mid_ram0 got=%h exp=%h",
               bus.rd_data, mem_m[0]);
    end
    while (p != 3 * HT + 5) step();
    checks++;
    if (bus.rd_data !== 8'h05) begin
      failures++;
      $display("FAIL mid_keep got=%h exp=05", bus.rd_data);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    p           = 0;
    reset       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    test_reset();
    test_horizontal();
    test_blanking();
    test_pixel();
    test_frame();
    test_write_during_read();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
